bcd_nibble_assembler: RTL and testbench

BCD_NIBBLE_ASSEMBLER -- requirements
Module: bcd_nibble_assembler

---
 rtl/bcd_nibble_assembler.sv | 157 +++++++++++++++
 tb/tb_bcd_nibble_assembler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_nibble_assembler.sv
// bcd_nibble_assembler
// Collects a serial bit stream into 4-bit nibbles, checks each nibble as a
// decimal code and presents accepted digits on a valid/ready output. Rejected
// nibbles raise a one-cycle err pulse and bump a saturating error counter.
//
// Parameter MSB_FIRST: 0 = first serial bit is nibble bit 0, 1 = first bit is bit 3.
// Macro BCD_XS3_INPUT_EN: when defined the nibble is excess-3 coded (3..12 valid,
// digit = nibble - 3); when undefined it is plain BCD (0..9 valid, digit = nibble).

module bcd_nibble_assembler #(
  parameter int MSB_FIRST = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic       ser_ready,
  input  logic       flush,
  output logic [3:0] digit,
  output logic       digit_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Is this nibble a legal code for the selected input coding?
  function automatic logic code_ok(input logic [3:0] n);
`ifdef BCD_XS3_INPUT_EN
    return (n >= 4'd3) && (n <= 4'd12);
`else
    return (n <= 4'd9);
`endif
  endfunction

  // Decimal digit carried by a legal nibble.
  function automatic logic [3:0] code_digit(input logic [3:0] n);
`ifdef BCD_XS3_INPUT_EN
    return n - 4'd3;
`else
    return n;
`endif
  endfunction

  state_t     state_r, state_s;
  logic [1:0] bit_cnt_r, bit_cnt_s;
  logic [3:0] shreg_r, shreg_s;
  logic [3:0] digit_r, digit_s;
  logic       digit_valid_r, digit_valid_s;
  logic       err_r, err_s;
  logic [3:0] err_cnt_r, err_cnt_s;
  logic [3:0] nibble_s;
  logic       accept_s;

  // Ready is a direct decode of the state register so it is glitch-free.
  assign ser_ready = (state_r != HOLD);

  // Flush wins over acceptance; HOLD never accepts because ready is low there.
  assign accept_s = ser_valid && (state_r != HOLD) && !flush;

  // Shift register contents including the bit presented this cycle.
  always_comb begin
    nibble_s = shreg_r;
    if (MSB_FIRST != 0) begin
      nibble_s = {shreg_r[2:0], ser_in};
    end else begin
      nibble_s[bit_cnt_r] = ser_in;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s       = state_r;
    bit_cnt_s     = bit_cnt_r;
    shreg_s       = shreg_r;
    digit_s       = digit_r;
    digit_valid_s = digit_valid_r;
    err_s         = 1'b0;
    err_cnt_s     = err_cnt_r;
    case (state_r)
      IDLE, SHIFT: begin
        if (flush) begin
          shreg_s   = 4'd0;
          bit_cnt_s = 2'd0;
          state_s   = IDLE;
        end else if (accept_s) begin
          if (bit_cnt_r == 2'd3) begin
            bit_cnt_s = 2'd0;
            shreg_s   = 4'd0;
            if (code_ok(nibble_s)) begin
              digit_s       = code_digit(nibble_s);
              digit_valid_s = 1'b1;
              state_s       = HOLD;
            end else begin
              err_s     = 1'b1;
              err_cnt_s = (err_cnt_r == 4'd15) ? 4'd15 : (err_cnt_r + 4'd1);
              state_s   = IDLE;
            end
          end else begin
            bit_cnt_s = bit_cnt_r + 2'd1;
            shreg_s   = nibble_s;
            state_s   = SHIFT;
          end
        end else begin
          state_s = state_r;
        end
      end
      HOLD: begin
        // The held digit survives flush; only the downstream handshake frees it.
        if (out_ready) begin
          digit_valid_s = 1'b0;
          state_s       = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s       = IDLE;
        bit_cnt_s     = 2'd0;
        shreg_s       = 4'd0;
        digit_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      bit_cnt_r     <= 2'd0;
      shreg_r       <= 4'd0;
      digit_r       <= 4'd0;
      digit_valid_r <= 1'b0;
      err_r         <= 1'b0;
      err_cnt_r     <= 4'd0;
    end else begin
      state_r       <= state_s;
      bit_cnt_r     <= bit_cnt_s;
      shreg_r       <= shreg_s;
      digit_r       <= digit_s;
      digit_valid_r <= digit_valid_s;
      err_r         <= err_s;
      err_cnt_r     <= err_cnt_s;
    end
  end

  assign digit       = digit_r;
  assign digit_valid = digit_valid_r;
  assign err         = err_r;
  assign err_cnt     = err_cnt_r;

endmodule

// File: tb/tb_bcd_nibble_assembler.sv
// Testbench for bcd_nibble_assembler: a table of nibbles with expected
// results plus directed sequences for flush, hold, saturation and reset.
// A scoreboard queue receives one entry per completed nibble and a monitor
// compares it against each err pulse or rising digit_valid.

module tb_bcd_nibble_assembler;

  logic       clk;
  logic       rst_n;
  logic       ser_in, ser_valid, flush, out_ready;
  logic       ser_ready, digit_valid, err;
  logic [3:0] digit, err_cnt;

  logic       m_ser_in, m_ser_valid, m_flush, m_out_ready;
  logic       m_ser_ready, m_digit_valid, m_err;
  logic [3:0] m_digit, m_err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_errs = 0;

  typedef struct {
    logic       is_err;
    logic [3:0] d;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [3:0] nib;
    int         hold;
    logic       exp_ok;
    logic [3:0] exp_digit;
  } vec_t;
  vec_t vecs[12];

  bcd_nibble_assembler #(.MSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(ser_ready), .flush(flush), .digit(digit),
    .digit_valid(digit_valid), .out_ready(out_ready), .err(err),
    .err_cnt(err_cnt)
  );

  bcd_nibble_assembler #(.MSB_FIRST(1)) dut_m (
    .clk(clk), .rst_n(rst_n), .ser_in(m_ser_in), .ser_valid(m_ser_valid),
    .ser_ready(m_ser_ready), .flush(m_flush), .digit(m_digit),
    .digit_valid(m_digit_valid), .out_ready(m_out_ready), .err(m_err),
    .err_cnt(m_err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference code model: {legal, digit}.
  function automatic logic [4:0] model(input logic [3:0] n);
`ifdef BCD_XS3_INPUT_EN
    return {(n >= 4'd3) && (n <= 4'd12), n - 4'd3};
`else
    return {(n <= 4'd9), n};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: each err pulse or new digit consumes one expectation.
  task automatic monitor();
    logic dv_prev;
    exp_t e;
    dv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dv_prev = 1'b0;
      end else begin
        if (err || (digit_valid && !dv_prev)) begin
          if (sbq.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("sb_kind", 32'(err), 32'(e.is_err));
            if (!e.is_err) check("sb_digit", 32'(digit), 32'(e.d));
          end
        end
        dv_prev = digit_valid;
      end
    end
  endtask

  // Present four bits LSB first; flush_last discards the nibble on its 4th bit.
  task automatic send_nibble(input logic [3:0] nib, input logic flush_last);
    int w;
    logic [4:0] m;
    exp_t e;
    w = 0;
    while (!ser_ready && w < 20) begin
      tick();
      w++;
    end
    if (w == 20) check("ready_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 4; k++) begin
      ser_in    = nib[k];
      ser_valid = 1'b1;
      if (k == 3) begin
        flush = flush_last;
        if (!flush_last) begin
          m = model(nib);
          e.is_err = !m[4];
          e.d      = m[3:0];
          sbq.push_back(e);
          if (!m[4] && exp_errs < 15) exp_errs++;
        end
      end
      tick();
    end
    ser_valid = 1'b0;
    flush     = 1'b0;
  endtask

  // Send one nibble, hold the output for 'hold' cycles, then release it.
  task automatic apply_vec(input logic [3:0] nib, input int hold,
                           input logic ok, input logic [3:0] d);
    out_ready = (hold == 0);
    send_nibble(nib, 1'b0);
    if (ok) begin
      for (int h = 0; h < hold; h++) begin
        check("hold_valid", 32'(digit_valid), 32'd1);
        check("hold_digit", 32'(digit), 32'(d));
        check("hold_ready", 32'(ser_ready), 32'd0);
        tick();
      end
      out_ready = 1'b1;
      check("out_valid", 32'(digit_valid), 32'd1);
      check("out_digit", 32'(digit), 32'(d));
      tick();
      check("released", 32'(digit_valid), 32'd0);
    end else begin
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_valid", 32'(digit_valid), 32'd0);
      tick();
      check("err_one_cycle", 32'(err), 32'd0);
    end
    check("err_cnt", 32'(err_cnt), 32'(exp_errs));
  endtask

  initial begin
    logic [4:0]  m;
    logic [3:0]  nibs[12];
    int          holds[12];
    logic [3:0]  mbits;

    nibs  = '{4'd1, 4'd0, 4'd9, 4'd5, 4'd12, 4'd3, 4'd15, 4'd7, 4'd10, 4'd2, 4'd13, 4'd8};
    holds = '{0, 3, 0, 1, 0, 2, 0, 4, 0, 0, 0, 2};
    for (int i = 0; i < 12; i++) begin
      m = model(nibs[i]);
      vecs[i].nib       = nibs[i];
      vecs[i].hold      = holds[i];
      vecs[i].exp_ok    = m[4];
      vecs[i].exp_digit = m[3:0];
    end

    rst_n = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    m_ser_in = 1'b0; m_ser_valid = 1'b0; m_flush = 1'b0; m_out_ready = 1'b0;
    fork monitor(); join_none
    #12;
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_valid", 32'(digit_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_ready", 32'(ser_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // LSB-first 1,0,0,1 -> 9, released the following cycle.
    m = model(4'b1001);
    apply_vec(4'b1001, 0, m[4], m[3:0]);

    // Table of nibbles.
    for (int i = 0; i < 12; i++)
      apply_vec(vecs[i].nib, vecs[i].hold, vecs[i].exp_ok, vecs[i].exp_digit);

    // Two bits, flush, then a clean nibble for 3.
    ser_in = 1'b1; ser_valid = 1'b1;
    tick(); tick();
    ser_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    m = model(4'd3);
    apply_vec(4'd3, 0, m[4], m[3:0]);

    // Flush on the 4th bit discards the nibble silently.
    send_nibble(4'd15, 1'b1);
    check("flush4_err", 32'(err), 32'd0);
    check("flush4_valid", 32'(digit_valid), 32'd0);
    check("flush4_ready", 32'(ser_ready), 32'd1);
    check("flush4_err_cnt", 32'(err_cnt), 32'(exp_errs));

    // Flush while holding leaves the digit in place.
    m = model(4'd6);
    out_ready = 1'b0;
    send_nibble(4'd6, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("hold_flush_valid", 32'(digit_valid), 32'(m[4]));
    check("hold_flush_digit", 32'(digit), 32'(m[4] ? m[3:0] : 4'd0));
    out_ready = 1'b1;
    tick();
    check("hold_flush_rel", 32'(digit_valid), 32'd0);

    // Twenty illegal nibbles drive the counter into saturation.
    for (int i = 0; i < 20; i++) apply_vec(4'd15, 0, 1'b0, 4'd0);
    check("err_cnt_sat", 32'(err_cnt), 32'd15);

    // MSB-first instance: 0,1,1,1 -> 7, held for 10 cycles with bits offered.
    m = model(4'b0111);
    mbits = 4'b0111;
    for (int k = 3; k >= 0; k--) begin
      m_ser_in = mbits[k]; m_ser_valid = 1'b1;
      tick();
    end
    m_ser_in = 1'b1;
    for (int h = 0; h < 10; h++) begin
      check("msb_valid", 32'(m_digit_valid), 32'(m[4]));
      check("msb_digit", 32'(m_digit), 32'(m[3:0]));
      check("msb_ready", 32'(m_ser_ready), 32'd0);
      tick();
    end
    m_ser_valid = 1'b0; m_out_ready = 1'b1;
    tick();
    check("msb_released", 32'(m_digit_valid), 32'd0);
    check("msb_ready_after", 32'(m_ser_ready), 32'd1);

    // Asynchronous reset in HOLD between clock edges.
    out_ready = 1'b0;
    send_nibble(4'd5, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(digit_valid), 32'd0);
    check("arst_digit", 32'(digit), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_ready", 32'(ser_ready), 32'd1);
    exp_errs = 0;
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;

    // First bit after reset is taken immediately.
    m = model(4'd4);
    apply_vec(4'd4, 0, m[4], m[3:0]);

    tick(); tick();
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
